fp_add4_arb: RTL and testbench

Round-robin arbiter sharing one pipelined FP_ADD4 four-operand single-precision adder among NREQ requesters. Accepts one 4-operand request per cycle over valid/ready, drives the adder operands, and tracks requester IDs through the adder pipeline. Returns each sum to its requester as a one-cycle response pulse. Caps outstanding operations per requester with a counter.

---
 rtl/fp_add4_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 37 +++
 rtl/fp_add4_arb.sv | 104 ++++++++++
 tb/tb_fp_add4_arb.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_add4_pkg.sv
// Shared types for the FP_ADD4 arbiter: operand bundles, pipeline tags and
// the outstanding-operation counter width.
package fp_add4_pkg;

  typedef logic [31:0] fp32_t;

  // a sits in the low word so the packed layout matches {d,c,b,a}
  typedef struct packed {
    fp32_t d;
    fp32_t c;
    fp32_t b;
    fp32_t a;
  } add4_req_t;

  localparam int CNT_W    = 4;
  localparam int TAG_ID_W = 3;

  typedef logic [CNT_W-1:0] cnt_t;

  // Tag id is sized for the largest supported requester count (8)
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible requester strictly after
// last_grant, wrapping around to last_grant itself.
module rr_arbiter
  import fp_add4_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  // Two passes keep every vector index a loop constant
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_grant && eligible[i] && (i > int'(last_grant))) begin
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
        any_grant = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any_grant && eligible[i] && (i <= int'(last_grant))) begin
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add4_arb.sv
// Round-robin front end for a shared four-operand FP adder: grants one request
// per cycle, tags it through the adder latency and returns the sum to its owner.
module fp_add4_arb
  import fp_add4_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 6,
  parameter int MAX_OUT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*128-1:0] req_data,
  output logic [NREQ-1:0]     req_ready,
  output fp32_t               add_a,
  output fp32_t               add_b,
  output fp32_t               add_c,
  output fp32_t               add_d,
  input  fp32_t               add_result,
  output logic [NREQ-1:0]     resp_valid,
  output fp32_t               resp_data
);

  localparam int ID_W = id_width(NREQ);

  logic [ID_W-1:0] last_grant_reg;
  cnt_t            out_cnt_reg [NREQ];
  tag_t            tag_reg [ADD_LAT];

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] resp_onehot;
  logic [ID_W-1:0] grant_idx;
  logic            any_grant;
  logic            transfer;
  add4_req_t       req_arr [NREQ];
  add4_req_t       operands;
  tag_t            last_tag;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign req_arr[gi]     = req_data[gi*128 +: 128];
    assign eligible[gi]    = req_valid[gi] && (out_cnt_reg[gi] < cnt_t'(MAX_OUT));
    assign resp_onehot[gi] = (last_tag.id == TAG_ID_W'(gi));
  end

  rr_arbiter #(.N(NREQ), .IW(ID_W)) u_arb (
    .eligible   (eligible),
    .last_grant (last_grant_reg),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_grant  (any_grant)
  );

  // Nothing is accepted while reset is high, so operands stay zero then too
  assign transfer  = any_grant && !reset;
  assign req_ready = transfer ? grant : '0;
  assign operands  = transfer ? req_arr[grant_idx] : '0;
  assign add_a     = operands.a;
  assign add_b     = operands.b;
  assign add_c     = operands.c;
  assign add_d     = operands.d;
  assign last_tag  = tag_reg[ADD_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= ID_W'(NREQ - 1);
    end else if (transfer) begin
      last_grant_reg <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < ADD_LAT; s++) tag_reg[s] <= '0;
    end else begin
      tag_reg[0] <= '{valid: transfer, id: TAG_ID_W'(grant_idx)};
      for (int s = 1; s < ADD_LAT; s++) tag_reg[s] <= tag_reg[s-1];
    end
  end

  // A grant and a response in the same cycle cancel out
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (reset) begin
        out_cnt_reg[i] <= '0;
      end else if (req_ready[i] && !resp_valid[i]) begin
        out_cnt_reg[i] <= out_cnt_reg[i] + 4'd1;
      end else if (!req_ready[i] && resp_valid[i]) begin
        out_cnt_reg[i] <= out_cnt_reg[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid <= last_tag.valid ? resp_onehot : '0;
      if (last_tag.valid) resp_data <= add_result;
    end
  end

endmodule

// File: tb/tb_fp_add4_arb.sv
// Directed bench for fp_add4_arb with a behavioural FP_ADD4 pipeline model.
module tb_fp_add4_arb;

  localparam int NREQ    = 4;
  localparam int ADD_LAT = 6;
  localparam int MAX_OUT = 2;

  localparam logic [31:0] ONE   = 32'h3F80_0000;
  localparam logic [31:0] TWO   = 32'h4000_0000;
  localparam logic [31:0] THREE = 32'h4040_0000;
  localparam logic [31:0] FOUR  = 32'h4080_0000;
  localparam logic [31:0] FIVE  = 32'h40A0_0000;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*128-1:0] req_data;
  logic [NREQ-1:0]     req_ready;
  logic [31:0]         add_a, add_b, add_c, add_d, add_result;
  logic [NREQ-1:0]     resp_valid;
  logic [31:0]         resp_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_add4_arb #(.NREQ(NREQ), .ADD_LAT(ADD_LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_c      (add_c),
    .add_d      (add_d),
    .add_result (add_result),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

  // Exact for the small normal values used here
  function automatic real to_real(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = 11'(f[30:23]) + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] to_fp32(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  logic [31:0] add_pipe [ADD_LAT];
  always @(posedge clk) begin
    add_pipe[0] <= to_fp32(to_real(add_a) + to_real(add_b) + to_real(add_c) + to_real(add_d));
    for (int k = 1; k < ADD_LAT; k++) add_pipe[k] <= add_pipe[k-1];
  end
  assign add_result = add_pipe[ADD_LAT-1];

  function automatic logic [127:0] pk(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic [NREQ-1:0] v, input logic [NREQ*128-1:0] d);
    @(negedge clk);
    reset     = rst;
    req_valid = v;
    req_data  = d;
    #1;
    if (|(req_valid & req_ready))
      $display("xfer t=%0t ready=%b ops=%h %h %h %h", $time, req_ready, add_a, add_b, add_c, add_d);
  endtask

  initial begin
    logic [NREQ*128-1:0] d;
    logic [NREQ*128-1:0] dc;
    logic [31:0]         sums [NREQ];
    logic [NREQ-1:0]     v;
    logic [31:0]         exp_rv;

    reset = 1'b1; req_valid = '0; req_data = '0;
    sums[0] = ONE; sums[1] = TWO; sums[2] = THREE; sums[3] = FOUR;
    dc = '0;
    for (int i = 0; i < NREQ; i++)
      dc[i*128 +: 128] = pk(ONE, (i >= 1) ? ONE : 32'h0, (i >= 2) ? ONE : 32'h0, (i >= 3) ? ONE : 32'h0);

    // Reset state, with requests pending that must not be granted
    cycle(1'b1, 4'hF, dc);
    cycle(1'b1, 4'hF, dc);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_add_a", add_a, 32'h0);

    // Single request from requester 0
    d = '0; d[127:0] = pk(32'h0, ONE, TWO, THREE);
    cycle(1'b0, 4'b0001, d);
    check("single_ready", 32'(req_ready), 32'h1);
    check("single_add_a", add_a, 32'h0);
    check("single_add_b", add_b, ONE);
    check("single_add_c", add_c, TWO);
    check("single_add_d", add_d, THREE);
    for (int k = 1; k <= ADD_LAT + 3; k++) begin
      cycle(1'b0, 4'b0000, d);
      if (k == 1) check("single_idle_add_b", add_b, 32'h0);
      check($sformatf("single_rv_k%0d", k), 32'(resp_valid), (k == ADD_LAT + 1) ? 32'h1 : 32'h0);
      if (k == ADD_LAT + 1) check("single_sum", resp_data, 32'h40C0_0000);
    end

    // Full contention from reset release
    cycle(1'b1, 4'b0000, dc);
    for (int t = 0; t < 24; t++) begin
      v = '0;
      for (int i = 0; i < NREQ; i++) v[i] = (t <= 12 + i);
      cycle(1'b0, v, dc);
      check($sformatf("cont_ready_t%0d", t), 32'(req_ready), (t < 16) ? 32'(1 << (t % 4)) : 32'h0);
      exp_rv = (t >= 7 && t < 23) ? 32'(1 << ((t - 7) % 4)) : 32'h0;
      check($sformatf("cont_rv_t%0d", t), 32'(resp_valid), exp_rv);
      if (t >= 7 && t < 23) check($sformatf("cont_sum_t%0d", t), resp_data, sums[(t - 7) % 4]);
    end

    // Outstanding cap on requester 2
    cycle(1'b1, 4'b0000, dc);
    d = '0; d[2*128 +: 128] = pk(TWO, 32'h0, 32'h0, 32'h0);
    for (int t = 0; t < 12; t++) begin
      cycle(1'b0, 4'b0100, d);
      check($sformatf("cap_ready_t%0d", t), 32'(req_ready),
            (t < 2 || t == 8 || t == 9) ? 32'h4 : 32'h0);
      check($sformatf("cap_rv_t%0d", t), 32'(resp_valid), (t == 7 || t == 8) ? 32'h4 : 32'h0);
      if (t == 7 || t == 8) check($sformatf("cap_sum_t%0d", t), resp_data, TWO);
      check($sformatf("cap_cnt_le_max_t%0d", t), 32'(dut.out_cnt_reg[2] <= 4'(MAX_OUT)), 32'h1);
    end

    // Increment and decrement in the same cycle on requester 1
    cycle(1'b1, 4'b0000, dc);
    d = '0; d[128 +: 128] = pk(TWO, 32'h0, 32'h0, 32'h0);
    cycle(1'b0, 4'b0010, d);
    check("incdec_ready0", 32'(req_ready), 32'h2);
    for (int k = 1; k < 7; k++) begin
      cycle(1'b0, 4'b0000, d);
      check($sformatf("incdec_rv_k%0d", k), 32'(resp_valid), 32'h0);
    end
    d[128 +: 128] = pk(ONE, ONE, ONE, ONE);
    cycle(1'b0, 4'b0010, d);
    check("incdec_ready7", 32'(req_ready), 32'h2);
    check("incdec_rv7", 32'(resp_valid), 32'h2);
    check("incdec_sum7", resp_data, TWO);
    check("incdec_cnt7", 32'(dut.out_cnt_reg[1]), 32'h1);
    for (int k = 8; k <= 15; k++) begin
      cycle(1'b0, 4'b0000, d);
      if (k == 8) check("incdec_cnt8", 32'(dut.out_cnt_reg[1]), 32'h1);
      check($sformatf("incdec_rv_k%0d", k), 32'(resp_valid), (k == 14) ? 32'h2 : 32'h0);
      if (k == 14) check("incdec_sum14", resp_data, FOUR);
      if (k == 15) check("incdec_cnt15", 32'(dut.out_cnt_reg[1]), 32'h0);
    end

    // Reset while three operations are in flight
    cycle(1'b1, 4'b0000, dc);
    cycle(1'b0, 4'b0111, dc);
    check("midrst_ready0", 32'(req_ready), 32'h1);
    cycle(1'b0, 4'b0110, dc);
    check("midrst_ready1", 32'(req_ready), 32'h2);
    cycle(1'b0, 4'b0100, dc);
    check("midrst_ready2", 32'(req_ready), 32'h4);
    cycle(1'b1, 4'b0000, dc);
    check("midrst_ready_in_reset", 32'(req_ready), 32'h0);
    d = '0;
    d[127:0]       = pk(THREE, FIVE, 32'h0, 32'h0);
    d[3*128 +: 128] = pk(ONE, 32'h0, 32'h0, 32'h0);
    cycle(1'b0, 4'b1001, d);
    check("midrst_first_grant", 32'(req_ready), 32'h1);
    check("midrst_resp_data_clr", resp_data, 32'h0);
    for (int i = 0; i < NREQ; i++)
      check($sformatf("midrst_cnt%0d", i), 32'(dut.out_cnt_reg[i]), 32'h0);
    cycle(1'b0, 4'b1000, d);
    check("midrst_second_grant", 32'(req_ready), 32'h8);
    for (int u = 2; u <= 9; u++) begin
      cycle(1'b0, 4'b0000, d);
      check($sformatf("midrst_rv_u%0d", u), 32'(resp_valid),
            (u == 7) ? 32'h1 : ((u == 8) ? 32'h8 : 32'h0));
      if (u == 7) check("midrst_sum0", resp_data, 32'h4100_0000);
      if (u == 8) check("midrst_sum3", resp_data, ONE);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
